// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential multiplier engine.
package mult_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    MULT,
    STORE,
    DONE
  } state_t;

  // Number of memory bytes spanned by one operand of width op_w.
  function automatic int unsigned bytes(input int unsigned op_w);
    return op_w / BYTE_W;
  endfunction

endpackage

// File: rtl/booth_mult_core.sv
// Radix-2 Booth signed multiplier, one recoding step per clock.
// The first step is folded into the load so that OP_W steps finish in OP_W cycles.
module booth_mult_core
  import mult_pkg::*;
#(
  parameter int unsigned OP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              valid,
  output logic [2*OP_W-1:0] product
);

  localparam int unsigned ACC_W = 2 * OP_W + 1;
  localparam int unsigned CNT_W = $clog2(OP_W) + 1;

  logic [ACC_W-1:0] acc_q;
  logic             qm1_q;
  logic [OP_W:0]    m_q;
  logic [CNT_W-1:0] cnt_q;

  logic             load_c;
  logic [ACC_W-1:0] src_acc_c;
  logic             src_qm1_c;
  logic [OP_W:0]    src_m_c;
  logic [OP_W:0]    hi_c;
  logic [ACC_W-1:0] step_acc_c;

  assign load_c  = go && !busy;
  assign product = acc_q[2*OP_W-1:0];

  // One Booth step on either a freshly loaded operand pair or the running accumulator.
  always_comb begin
    src_acc_c = acc_q;
    src_qm1_c = qm1_q;
    src_m_c   = m_q;
    if (load_c) begin
      src_acc_c = {{(OP_W + 1){1'b0}}, b};
      src_qm1_c = 1'b0;
      src_m_c   = {a[OP_W-1], a};
    end
    hi_c = src_acc_c[ACC_W-1:OP_W];
    case ({src_acc_c[0], src_qm1_c})
      2'b01:   hi_c = hi_c + src_m_c;
      2'b10:   hi_c = hi_c - src_m_c;
      default: hi_c = src_acc_c[ACC_W-1:OP_W];
    endcase
    step_acc_c = {hi_c[OP_W], hi_c, src_acc_c[OP_W-1:1]};
  end

  // Step sequencing; valid pulses once the final step has landed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      qm1_q <= 1'b0;
      m_q   <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (load_c) begin
        acc_q <= step_acc_c;
        qm1_q <= src_acc_c[0];
        m_q   <= src_m_c;
        cnt_q <= CNT_W'(OP_W - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        acc_q <= step_acc_c;
        qm1_q <= src_acc_c[0];
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy  <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mult_seq_engine.sv
// Memory-mapped sequential signed multiplier: reads operand pairs, writes products back.
module mult_seq_engine
  import mult_pkg::*;
#(
  parameter int unsigned OP_W     = 8,
  parameter int          N_PAIRS  = 1,
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned DST_BASE = 2,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [BYTE_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [BYTE_W-1:0] mem_wr_data,
  output logic [15:0]       pair_idx
);

  localparam int unsigned OB     = bytes(OP_W);
  localparam int unsigned STRIDE = 2 * OB;
  localparam int unsigned CNT_W  = 4;

  if (N_PAIRS < 1) begin : g_bad_pairs
    $error("mult_seq_engine: N_PAIRS must be at least 1");
  end
  if ((OP_W % BYTE_W) != 0 || OP_W < 8 || OP_W > 32) begin : g_bad_width
    $error("mult_seq_engine: OP_W must be a multiple of 8 in 8..32");
  end

  state_t              state;
  logic                start_q;
  logic [CNT_W-1:0]    byte_cnt;
  logic [OP_W-1:0]     a_reg;
  logic [OP_W-1:0]     b_reg;
  logic [ADDR_W-1:0]   src_ptr;
  logic [ADDR_W-1:0]   dst_ptr;

  logic                core_go_c;
  logic                core_busy;
  logic                core_valid;
  logic [2*OP_W-1:0]   core_product;
  logic [OP_W-1:0]     a_shift_c;
  logic [OP_W-1:0]     b_shift_c;
  logic [BYTE_W-1:0]   next_byte_c;
  logic                start_fall_c;
  logic                launch_c;

  // Operands arrive LSB first, so each new byte enters at the top and shifts down.
  assign a_shift_c    = OP_W'({mem_rd_data, a_reg} >> BYTE_W);
  assign b_shift_c    = OP_W'({mem_rd_data, b_reg} >> BYTE_W);
  assign next_byte_c  = BYTE_W'(core_product >> (BYTE_W * (int'(byte_cnt) + 1)));
  assign start_fall_c = start_q && !start;
  assign launch_c     = start_fall_c && (state == IDLE || state == DONE);
  assign core_go_c    = (state == LOAD_B) && (byte_cnt == CNT_W'(OB - 1)) && !core_busy;

  booth_mult_core #(.OP_W(OP_W)) u_core (
    .clk     (clk),
    .reset   (reset),
    .go      (core_go_c),
    .a       (a_reg),
    .b       (b_shift_c),
    .busy    (core_busy),
    .valid   (core_valid),
    .product (core_product)
  );

  // Sequencer: edge detect, byte loads, multiply wait, product stores, pair stepping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      start_q     <= 1'b1;
      done        <= 1'b0;
      busy        <= 1'b0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      pair_idx    <= '0;
      byte_cnt    <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      src_ptr     <= '0;
      dst_ptr     <= '0;
    end else begin
      start_q <= start;
      if (launch_c) begin
        state    <= LOAD_A;
        done     <= 1'b0;
        busy     <= 1'b1;
        pair_idx <= '0;
        byte_cnt <= '0;
        src_ptr  <= ADDR_W'(SRC_BASE);
        dst_ptr  <= ADDR_W'(DST_BASE);
        mem_addr <= ADDR_W'(SRC_BASE);
      end else begin
        case (state)
          IDLE: begin
            done <= 1'b0;
          end
          LOAD_A: begin
            a_reg    <= a_shift_c;
            mem_addr <= mem_addr + ADDR_W'(1);
            if (byte_cnt == CNT_W'(OB - 1)) begin
              state    <= LOAD_B;
              byte_cnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
          LOAD_B: begin
            b_reg    <= b_shift_c;
            mem_addr <= mem_addr + ADDR_W'(1);
            if (byte_cnt == CNT_W'(OB - 1)) begin
              state    <= MULT;
              byte_cnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
          MULT: begin
            if (core_valid) begin
              state       <= STORE;
              byte_cnt    <= '0;
              mem_addr    <= dst_ptr;
              mem_wr_en   <= 1'b1;
              mem_wr_data <= core_product[BYTE_W-1:0];
            end
          end
          STORE: begin
            if (byte_cnt == CNT_W'(STRIDE - 1)) begin
              mem_wr_en <= 1'b0;
              byte_cnt  <= '0;
              if (pair_idx == 16'(N_PAIRS - 1)) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state    <= LOAD_A;
                pair_idx <= pair_idx + 16'd1;
                src_ptr  <= src_ptr + ADDR_W'(STRIDE);
                dst_ptr  <= dst_ptr + ADDR_W'(STRIDE);
                mem_addr <= src_ptr + ADDR_W'(STRIDE);
              end
            end else begin
              byte_cnt    <= byte_cnt + CNT_W'(1);
              mem_addr    <= mem_addr + ADDR_W'(1);
              mem_wr_data <= next_byte_c;
            end
          end
          DONE: begin
            if (start) begin
              state <= IDLE;
              done  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
